// File: rtl/draw_car.sv
// draw_car: sprite-overlay stage that sits directly after draw_background.
//
// Draws a CAR_WIDTH x CAR_HEIGHT bitmap, fetched from an external synchronous ROM,
// over the incoming background stream. ROM pixels equal to KEY_COLOR are transparent.
// The sprite position is captured on the vblank rising edge, so a frame is always
// drawn at a single position and the sprite never tears.
//
// Ports:
//   clk, rst                     pixel clock, synchronous active-high reset
//   hcount_in, vcount_in         pixel / line counters (1024x768 timing)
//   hsync_in, vsync_in           sync strobes aligned with the counters
//   hblnk_in, vblnk_in           blanking flags
//   rgb_in                       background colour
//   xpos, ypos                   requested sprite top-left corner
//   rom_addr                     {row, col} into the car ROM (combinational)
//   rom_rgb                      ROM data, valid one clk after rom_addr
//   *_out                        timing signals delayed by exactly 2 clk
//   rgb_out                      composited colour aligned with the *_out signals
module draw_car #(
    parameter int unsigned CAR_WIDTH  = 128,
    parameter int unsigned CAR_HEIGHT = 64,
    parameter logic [11:0] KEY_COLOR  = 12'hF0F,
    parameter logic [10:0] XPOS_INIT  = 11'd448,
    parameter logic [10:0] YPOS_INIT  = 11'd480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [10:0] xpos,
    input  logic [10:0] ypos,
    output logic [$clog2(CAR_HEIGHT)+$clog2(CAR_WIDTH)-1:0] rom_addr,
    input  logic [11:0] rom_rgb,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam int unsigned ColW = $clog2(CAR_WIDTH);
    localparam int unsigned RowW = $clog2(CAR_HEIGHT);

    // Frame-synchronous position latch
    logic [10:0] xpos_l_q, xpos_l_d;
    logic [10:0] ypos_l_q, ypos_l_d;
    logic        vblnk_prev_q;
    logic        latch_en;

    // Stage 1 registers
    logic [10:0] hcount_s1_q, vcount_s1_q;
    logic        hsync_s1_q, vsync_s1_q, hblnk_s1_q, vblnk_s1_q;
    logic [11:0] rgb_s1_q;
    logic        in_spr_s1_q;

    // Stage 0 combinational signals
    logic [11:0] x_end, y_end;
    logic        in_spr;
    logic [11:0] rgb_d;

    assign latch_en = vblnk_in && !vblnk_prev_q;

    always_comb begin
        xpos_l_d = xpos_l_q;
        ypos_l_d = ypos_l_q;
        if (latch_en) begin
            xpos_l_d = xpos;
            ypos_l_d = ypos;
        end
    end

    // Sprite extents are formed one bit wider so a sprite near the top of the
    // counter range clips instead of wrapping around to column/line 0.
    always_comb begin
        x_end  = {1'b0, xpos_l_q} + 12'(CAR_WIDTH);
        y_end  = {1'b0, ypos_l_q} + 12'(CAR_HEIGHT);
        in_spr = (hcount_in >= xpos_l_q) && ({1'b0, hcount_in} < x_end) &&
                 (vcount_in >= ypos_l_q) && ({1'b0, vcount_in} < y_end) &&
                 !hblnk_in && !vblnk_in;
    end

    // Only meaningful while in_spr is set; outside the sprite the ROM read is ignored.
    assign rom_addr = {RowW'(vcount_in - ypos_l_q), ColW'(hcount_in - xpos_l_q)};

    always_comb begin
        rgb_d = rgb_s1_q;
        if (in_spr_s1_q && (rom_rgb != KEY_COLOR)) begin
            rgb_d = rom_rgb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xpos_l_q     <= XPOS_INIT;
            ypos_l_q     <= YPOS_INIT;
            vblnk_prev_q <= 1'b0;
            hcount_s1_q  <= '0;
            vcount_s1_q  <= '0;
            hsync_s1_q   <= 1'b0;
            vsync_s1_q   <= 1'b0;
            hblnk_s1_q   <= 1'b0;
            vblnk_s1_q   <= 1'b0;
            rgb_s1_q     <= '0;
            in_spr_s1_q  <= 1'b0;
            hcount_out   <= '0;
            vcount_out   <= '0;
            hsync_out    <= 1'b0;
            vsync_out    <= 1'b0;
            hblnk_out    <= 1'b0;
            vblnk_out    <= 1'b0;
            rgb_out      <= '0;
        end else begin
            xpos_l_q     <= xpos_l_d;
            ypos_l_q     <= ypos_l_d;
            vblnk_prev_q <= vblnk_in;
            hcount_s1_q  <= hcount_in;
            vcount_s1_q  <= vcount_in;
            hsync_s1_q   <= hsync_in;
            vsync_s1_q   <= vsync_in;
            hblnk_s1_q   <= hblnk_in;
            vblnk_s1_q   <= vblnk_in;
            rgb_s1_q     <= rgb_in;
            in_spr_s1_q  <= in_spr;
            hcount_out   <= hcount_s1_q;
            vcount_out   <= vcount_s1_q;
            hsync_out    <= hsync_s1_q;
            vsync_out    <= vsync_s1_q;
            hblnk_out    <= hblnk_s1_q;
            vblnk_out    <= vblnk_s1_q;
            rgb_out      <= rgb_d;
        end
    end

endmodule
